// File: rtl/cachepool_pkg.sv
// Shared types and constants for the CachePool host-side boot sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cachepool_pkg;

  // Boot-control register location: cluster peripheral window plus register offset.
  localparam logic [47:0] PeriphStartAddr = 48'h0000_0000_0000;
  localparam logic [47:0] BootCtrlOffset  = 48'h0000_0000_0000;
  localparam logic [47:0] BootCtrlAddr    = PeriphStartAddr + BootCtrlOffset;

  // Cycles between the start command and the boot-control write.
  localparam int unsigned DefaultStartDelay = 1000;

  typedef enum logic [2:0] {
    IDLE,
    DELAY,
    REQ,
    RESP,
    WAKE,
    RUN,
    DONE,
    ERR
  } boot_state_e;

endpackage

// File: rtl/cachepool_boot_timer.sv
// Loadable, clearable, saturating up-counter with a "count == limit-1" flag.
// Latency: count updates one cycle after clr/load/en; last_o is combinational on the count.
// Backpressure: none; en_i simply stalls the count.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   clr_i                force count to 0 (highest priority)
//   load_i, load_val_i   load an arbitrary count
//   en_i                 increment by one, holding at all-ones
//   limit_i              terminal value; last_o = (cnt_o == limit_i - 1)
//   cnt_o, last_o        current count and terminal flag
module cachepool_boot_timer #(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [CntWidth-1:0] load_val_i,
  input  logic                en_i,
  input  logic [CntWidth-1:0] limit_i,
  output logic [CntWidth-1:0] cnt_o,
  output logic                last_o
);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != {CntWidth{1'b1}})) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  assign cnt_o  = cnt_q;
  // A limit of 0 wraps to all-ones here; callers that allow 0 gate the flag themselves.
  assign last_o = (cnt_q == (limit_i - CntWidth'(1)));

endmodule

// File: rtl/cachepool_boot_ctrl.sv
// Host-side boot sequencer: delay, write entry point over reqrsp, pulse debug_req, supervise run.
// Latency: q_valid_o rises StartDelay+1 cycles after an accepted start; all outputs decode the state register.
// Backpressure: holds the request stable until q_ready_i; waits indefinitely in RESP for p_valid_i.
//
// Ports:
//   clk_i, rst_i                    clock, synchronous active-high reset
//   start_i, entry_point_i          boot command and boot address (accepted in IDLE/DONE/ERR)
//   eoc_i                           cluster end-of-computation, honoured only in RUN
//   q_*                             reqrsp request channel (single 32-bit write)
//   p_*                             reqrsp response channel
//   debug_req_o                     core wake-up pulse
//   busy_o, done_o, error_o,
//   timeout_o, run_cycles_o         status; flags are sticky until the next accepted start
module cachepool_boot_ctrl
  import cachepool_pkg::*;
#(
  parameter int unsigned          AddrWidth     = 48,
  parameter logic [AddrWidth-1:0] BootCtrlAddr  = AddrWidth'(cachepool_pkg::BootCtrlAddr),
  parameter int unsigned          StartDelay    = cachepool_pkg::DefaultStartDelay,
  parameter int unsigned          DebugPulseLen = 1,
  parameter int unsigned          TimeoutCycles = 0,
  parameter int unsigned          CntWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          entry_point_i,
  input  logic                 eoc_i,
  output logic                 q_valid_o,
  input  logic                 q_ready_i,
  output logic [AddrWidth-1:0] q_addr_o,
  output logic [31:0]          q_data_o,
  output logic                 q_write_o,
  output logic [3:0]           q_strb_o,
  input  logic                 p_valid_i,
  output logic                 p_ready_o,
  input  logic                 p_error_i,
  output logic                 debug_req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 timeout_o,
  output logic [CntWidth-1:0]  run_cycles_o
);

  boot_state_e state_q, state_d;

  logic [31:0]         entry_q;
  logic                done_q, error_q, timeout_q;
  logic                start_acc;
  logic                delay_last, pulse_last, run_last, timeout_hit;
  logic [CntWidth-1:0] delay_cnt, pulse_cnt;

  assign start_acc   = start_i && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
  assign timeout_hit = (TimeoutCycles != 0) && run_last;

  // ---------------------------------------------------------------- counters
  // Delay and pulse counters restart whenever their state is not active, so
  // each visit counts from 0. The run counter clears only on a new start so
  // its value survives into DONE/ERR.
  cachepool_boot_timer #(.CntWidth(CntWidth)) u_delay_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (state_q != DELAY),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == DELAY),
    .limit_i    (CntWidth'(StartDelay)),
    .cnt_o      (delay_cnt),
    .last_o     (delay_last)
  );

  cachepool_boot_timer #(.CntWidth(CntWidth)) u_pulse_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (state_q != WAKE),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == WAKE),
    .limit_i    (CntWidth'(DebugPulseLen)),
    .cnt_o      (pulse_cnt),
    .last_o     (pulse_last)
  );

  cachepool_boot_timer #(.CntWidth(CntWidth)) u_run_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (start_acc),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == RUN),
    .limit_i    (CntWidth'(TimeoutCycles)),
    .cnt_o      (run_cycles_o),
    .last_o     (run_last)
  );

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_i) state_d = (StartDelay == 0) ? REQ : DELAY;
      end
      DELAY: begin
        if (delay_last) state_d = REQ;
      end
      REQ: begin
        if (q_ready_i) state_d = RESP;
      end
      RESP: begin
        if (p_valid_i) state_d = p_error_i ? ERR : WAKE;
      end
      WAKE: begin
        if (pulse_last) state_d = RUN;
      end
      RUN: begin
        // EOC wins over a timeout landing in the same cycle.
        if (eoc_i)            state_d = DONE;
        else if (timeout_hit) state_d = ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    q_valid_o   = 1'b0;
    p_ready_o   = 1'b0;
    debug_req_o = 1'b0;
    busy_o      = 1'b0;
    case (state_q)
      DELAY: busy_o = 1'b1;
      REQ: begin
        busy_o    = 1'b1;
        q_valid_o = 1'b1;
      end
      RESP: begin
        busy_o    = 1'b1;
        p_ready_o = 1'b1;
      end
      WAKE: begin
        busy_o      = 1'b1;
        debug_req_o = 1'b1;
      end
      RUN:     busy_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  // Request payload is only driven alongside valid so an idle bus reads as zero.
  assign q_addr_o  = q_valid_o ? BootCtrlAddr : '0;
  assign q_data_o  = q_valid_o ? entry_q : 32'h0;
  assign q_write_o = q_valid_o;
  assign q_strb_o  = q_valid_o ? 4'hF : 4'h0;

  // ---------------------------------------------------------------- sticky status and entry latch
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entry_q   <= 32'h0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (start_acc) begin
        entry_q   <= entry_point_i;
        done_q    <= 1'b0;
        error_q   <= 1'b0;
        timeout_q <= 1'b0;
      end
      if ((state_q == RESP) && p_valid_i && p_error_i) begin
        error_q <= 1'b1;
      end
      if (state_q == RUN) begin
        if (eoc_i) begin
          done_q <= 1'b1;
        end else if (timeout_hit) begin
          error_q   <= 1'b1;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign done_o    = done_q;
  assign error_o   = error_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_cachepool_boot_ctrl.sv
// Self-checking bench for cachepool_boot_ctrl: directed boot sequences with randomized waits.
// Latency: n/a.
// Backpressure: the bench drives q_ready_i / p_valid_i with randomized stalls.
module tb_cachepool_boot_ctrl;

  localparam int unsigned          AW  = 48;
  localparam logic [AW-1:0]        BCA = 48'h0000_1234_5678;
  localparam int                   SD  = 4;
  localparam int                   DPL = 2;
  localparam int                   TO  = 20;
  localparam int unsigned          CW  = 32;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          start_i;
  logic [31:0]   entry_point_i;
  logic          eoc_i;
  logic          q_valid_o;
  logic          q_ready_i;
  logic [AW-1:0] q_addr_o;
  logic [31:0]   q_data_o;
  logic          q_write_o;
  logic [3:0]    q_strb_o;
  logic          p_valid_i;
  logic          p_ready_o;
  logic          p_error_i;
  logic          debug_req_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic          timeout_o;
  logic [CW-1:0] run_cycles_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cachepool_boot_ctrl #(
    .AddrWidth     (AW),
    .BootCtrlAddr  (BCA),
    .StartDelay    (SD),
    .DebugPulseLen (DPL),
    .TimeoutCycles (TO),
    .CntWidth      (CW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .entry_point_i (entry_point_i),
    .eoc_i         (eoc_i),
    .q_valid_o     (q_valid_o),
    .q_ready_i     (q_ready_i),
    .q_addr_o      (q_addr_o),
    .q_data_o      (q_data_o),
    .q_write_o     (q_write_o),
    .q_strb_o      (q_strb_o),
    .p_valid_i     (p_valid_i),
    .p_ready_o     (p_ready_o),
    .p_error_i     (p_error_i),
    .debug_req_o   (debug_req_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .timeout_o     (timeout_o),
    .run_cycles_o  (run_cycles_o)
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string phase);
    chk({phase, "_q_valid"},  q_valid_o,    0);
    chk({phase, "_q_addr"},   q_addr_o,     0);
    chk({phase, "_q_data"},   q_data_o,     0);
    chk({phase, "_q_write"},  q_write_o,    0);
    chk({phase, "_q_strb"},   q_strb_o,     0);
    chk({phase, "_p_ready"},  p_ready_o,    0);
    chk({phase, "_debug"},    debug_req_o,  0);
    chk({phase, "_busy"},     busy_o,       0);
    chk({phase, "_done"},     done_o,       0);
    chk({phase, "_error"},    error_o,      0);
    chk({phase, "_timeout"},  timeout_o,    0);
    chk({phase, "_run"},      run_cycles_o, 0);
  endtask

  // One full boot. The expected outcome comes from the rules alone: the run
  // ends at the EOC cycle if it arrives no later than the timeout cycle,
  // otherwise at the timeout cycle; the counter then shows that cycle count.
  task automatic boot(input logic [31:0] entry, input int rdy_wait, input int resp_wait,
                      input bit perr, input int eoc_at);
    bit exp_done;
    int run_end;
    exp_done = (eoc_at != 0) && (eoc_at <= TO);
    run_end  = exp_done ? eoc_at : TO;

    start_i = 1'b1; entry_point_i = entry; eoc_i = 1'($urandom_range(0, 1));
    tick();
    start_i = 1'b0; entry_point_i = $urandom;
    chk("start_busy",        busy_o,       1);
    chk("start_done_clr",    done_o,       0);
    chk("start_error_clr",   error_o,      0);
    chk("start_timeout_clr", timeout_o,    0);
    chk("start_run_clr",     run_cycles_o, 0);

    // Delay: no request during the first SD cycles after start.
    for (int i = 1; i <= SD; i++) begin
      chk("delay_no_valid", q_valid_o, 0);
      eoc_i = 1'($urandom_range(0, 1));
      tick();
    end

    // Request phase, cycle SD+1 after start.
    chk("req_valid", q_valid_o, 1);
    chk("req_addr",  q_addr_o,  BCA);
    chk("req_data",  q_data_o,  entry);
    chk("req_write", q_write_o, 1);
    chk("req_strb",  q_strb_o,  4'hF);
    chk("req_pready", p_ready_o, 0);
    q_ready_i = 1'b0;
    for (int w = 0; w < rdy_wait; w++) begin
      // Stray start/response activity must not disturb the request.
      start_i = 1'($urandom_range(0, 1)); entry_point_i = $urandom;
      p_valid_i = 1'($urandom_range(0, 1)); p_error_i = 1'b1;
      tick();
      chk("req_hold_valid",  q_valid_o, 1);
      chk("req_hold_addr",   q_addr_o,  BCA);
      chk("req_hold_data",   q_data_o,  entry);
      chk("req_hold_pready", p_ready_o, 0);
    end
    start_i = 1'b0; p_valid_i = 1'b0; p_error_i = 1'b0;
    q_ready_i = 1'b1;
    tick();
    q_ready_i = 1'b0;

    // Response phase.
    chk("resp_valid_low", q_valid_o, 0);
    for (int w = 0; w < resp_wait; w++) begin
      chk("resp_pready", p_ready_o,   1);
      chk("resp_debug",  debug_req_o, 0);
      p_error_i = 1'($urandom_range(0, 1));
      tick();
    end
    chk("resp_pready_final", p_ready_o, 1);
    p_valid_i = 1'b1; p_error_i = perr;
    tick();
    p_valid_i = 1'b0; p_error_i = 1'b0;

    if (perr) begin
      chk("berr_error",   error_o,     1);
      chk("berr_timeout", timeout_o,   0);
      chk("berr_done",    done_o,      0);
      chk("berr_busy",    busy_o,      0);
      chk("berr_debug",   debug_req_o, 0);
      repeat (3) begin
        eoc_i = 1'($urandom_range(0, 1));
        tick();
        chk("berr_debug_hold", debug_req_o, 0);
        chk("berr_error_hold", error_o,     1);
      end
      eoc_i = 1'b0;
      return;
    end

    // Wake pulse; EOC here is ignored.
    for (int i = 0; i < DPL; i++) begin
      chk("wake_debug", debug_req_o, 1);
      chk("wake_busy",  busy_o,      1);
      eoc_i = 1'($urandom_range(0, 1));
      tick();
    end
    chk("run_debug_low", debug_req_o, 0);

    // Run phase: the counter shows completed RUN cycles.
    for (int r = 1; r <= run_end; r++) begin
      chk("run_count", run_cycles_o, 64'(r - 1));
      chk("run_busy",  busy_o,       1);
      chk("run_done",  done_o,       0);
      eoc_i = (r == eoc_at);
      if (r == 3) begin
        start_i = 1'b1; entry_point_i = $urandom;
      end else begin
        start_i = 1'b0;
      end
      tick();
    end
    eoc_i = 1'b0; start_i = 1'b0;

    chk("end_done",    done_o,       exp_done);
    chk("end_error",   error_o,      !exp_done);
    chk("end_timeout", timeout_o,    !exp_done);
    chk("end_run",     run_cycles_o, 64'(run_end));
    chk("end_busy",    busy_o,       0);
    repeat (3) begin
      eoc_i = 1'($urandom_range(0, 1));
      tick();
      chk("end_run_hold",  run_cycles_o, 64'(run_end));
      chk("end_done_hold", done_o,       exp_done);
    end
    eoc_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; entry_point_i = 32'h0; eoc_i = 1'b0;
    q_ready_i = 1'b0; p_valid_i = 1'b0; p_error_i = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_i = 1'b0;
    tick();
    chk_all_zero("idle");

    // Ready immediately, EOC on RUN cycle 10.
    boot(32'h8000_0000, 0, 0, 1'b0, 10);
    // Ready stalled 7 cycles, response after 3 cycles.
    boot($urandom, 7, 3, 1'b0, 10 + int'($urandom_range(0, 8)));
    // Bus error on the response.
    boot($urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b1, 5);
    // No EOC: timeout.
    boot($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 0);
    // EOC in the same cycle the timeout would fire.
    boot($urandom, 1, 1, 1'b0, TO);
    // EOC in the first RUN cycle.
    boot($urandom, 0, 2, 1'b0, 1);

    // Reset while the request is pending.
    start_i = 1'b1; entry_point_i = $urandom;
    tick();
    start_i = 1'b0;
    repeat (SD) tick();
    chk("abort_req_valid", q_valid_o, 1);
    rst_i = 1'b1;
    tick();
    chk_all_zero("abort");
    rst_i = 1'b0;
    tick();
    chk_all_zero("abort_idle");

    // Fresh sequence after the abort, then randomized follow-ups from DONE/ERR.
    boot(32'hCAFE_0000, 2, 1, 1'b0, 7);
    for (int n = 0; n < 6; n++) begin
      boot($urandom, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 25)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cachepool_boot_ctrl.md
Name: cachepool_boot_ctrl

Overview:
Host-side boot sequencer for the CachePool cluster. It replaces hand-written bench boot code with synthesizable logic. After a start command it waits a programmable delay, then writes the entry point into the cluster peripheral boot-control register over a reqrsp port. It then pulses the cluster debug request to wake the cores, and supervises the run until end-of-computation (EOC), a timeout, or a bus error. It sits between the SoC/host control logic and the cluster's AXI-in path (upstream of a reqrsp_to_axi converter), and drives the cluster's debug_req input.

Parameters:
AddrWidth, 48, reqrsp address width (matches cluster AXI-in address width)
BootCtrlAddr, 48'h0, absolute address of the boot-control register (peripheral base + boot-control offset)
StartDelay, 1000, cycles waited in DELAY before issuing the write; 0 means skip DELAY
DebugPulseLen, 1, debug_req_o high time in cycles; must be >= 1
TimeoutCycles, 0, maximum RUN cycles before timeout; 0 disables the timeout
CntWidth, 32, width of the delay, pulse and run counters

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  begin a boot sequence; sampled in IDLE/DONE/ERR only
entry_point_i  in  32  boot address; latched on the accepted start
eoc_i  in  1  cluster end-of-computation
q_valid_o  out  1  reqrsp request valid
q_ready_i  in  1  reqrsp request ready
q_addr_o  out  AddrWidth  request address, constant BootCtrlAddr
q_data_o  out  32  request data, the latched entry point
q_write_o  out  1  request write flag, 1 when q_valid_o is high
q_strb_o  out  4  byte strobes, 4'hF when q_valid_o is high
p_valid_i  in  1  reqrsp response valid
p_ready_o  out  1  reqrsp response ready
p_error_i  in  1  response error flag
debug_req_o  out  1  core wake-up pulse
busy_o  out  1  high in DELAY/REQ/RESP/WAKE/RUN
done_o  out  1  sticky: run finished with EOC
error_o  out  1  sticky: bus error or timeout
timeout_o  out  1  sticky: error was a timeout
run_cycles_o  out  CntWidth  cycles spent in RUN; saturating; held after the run ends

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; latched entry point 0. Reset mid-operation aborts immediately: q_valid_o and debug_req_o drop in the next cycle and no response is awaited.
- State machine:
  - IDLE: on start_i, latch entry_point_i, clear done_o, error_o, timeout_o and run_cycles_o, and go to DELAY (REQ if StartDelay=0).
  - DELAY: counter runs 0..StartDelay-1, then go to REQ. q_valid_o therefore rises StartDelay+1 cycles after the cycle in which start_i was sampled.
  - REQ: q_valid_o=1 with stable address, data, write and strobe. On q_valid_o && q_ready_i, go to RESP. p_ready_o=0 in REQ; a p_valid_i seen in REQ is not consumed.
  - RESP: p_ready_o=1, q_valid_o=0. On p_valid_i: if p_error_i, set error_o and go to ERR; otherwise go to WAKE.
  - WAKE: debug_req_o=1 for exactly DebugPulseLen cycles, then go to RUN.
  - RUN: run_cycles_o increments every cycle and saturates at all-ones. If eoc_i, set done_o and go to DONE. Else, if TimeoutCycles!=0 and run_cycles_o reaches TimeoutCycles-1, set error_o and timeout_o and go to ERR.
  - DONE / ERR: idle; sticky flags are held. start_i restarts exactly as from IDLE.
- eoc_i is ignored outside RUN, including during WAKE. EOC takes priority over a timeout in the same cycle.
- start_i is ignored while busy_o=1.
- The run counter counts RUN cycles, including the cycle in which eoc_i is seen. EOC in the first RUN cycle gives run_cycles_o=1.

Decomposition:
- cachepool_pkg gains:
  - boot_state_e enum: IDLE, DELAY, REQ, RESP, WAKE, RUN, DONE, ERR
  - BootCtrlAddr localparam: peripheral start address + boot-control offset
  - default StartDelay constant
- One sub-module, cachepool_boot_timer: a loadable, clearable, saturating CntWidth up-counter with an enable and a "count == limit-1" flag.
  - Three instances: delay, pulse and run/timeout counting.

Test Plan:
1. StartDelay=4, start_i with entry 0x8000_0000, q_ready_i tied 1 → q_valid_o high exactly 5 cycles after start, q_data_o=0x80000000, q_strb_o=4'hF, q_write_o=1.
2. Hold q_ready_i=0 for 7 cycles in REQ → q_valid_o, address and data stable for all 8 cycles. p_valid_i after 3 cycles, no error → debug_req_o high for DebugPulseLen=2 cycles.
3. eoc_i pulsed 3 cycles after WAKE, and again 10 cycles into RUN → the early pulse is ignored; done_o=1 and run_cycles_o=10.
4. Response with p_error_i=1 → error_o=1, timeout_o=0, debug_req_o never asserts, busy_o=0.
5. TimeoutCycles=20 with no EOC → after 20 RUN cycles, error_o=1, timeout_o=1, run_cycles_o=20. EOC and timeout in the same cycle → done_o=1, error_o=0.
6. Assert rst_i while in REQ, then restart with start_i=1 in DONE → after reset all outputs are 0; on restart the sticky flags clear and the full sequence repeats with the new entry point.
